// File: rtl/munoc_axi_slave_tid_remapper_pkg.sv
// TID remapper shared definitions.
// Slot-count width and parameter legality helpers.
package munoc_axi_slave_tid_remapper_pkg;

   function automatic int cnt_width(input int max_out);
      return (max_out < 1) ? 1 : $clog2(max_out + 1);
   endfunction

   function automatic bit params_ok(
      input int bw_slv,
      input int n_wr,
      input int n_rd,
      input int max_out
   );
      return (n_wr >= 1) && (n_wr <= (1 << bw_slv)) &&
             (n_rd >= 1) && (n_rd <= (1 << bw_slv)) &&
             (max_out >= 1);
   endfunction

endpackage

// File: rtl/munoc_axi_slave_tid_remapper_slot_table.sv
// One direction's slot table: maps wide network TIDs onto
// slave slots, counts outstanding transactions per slot.
module munoc_tid_slot_table
   import munoc_axi_slave_tid_remapper_pkg::*;
#(
   parameter int NUM_SLOT        = 4,
   parameter int BW_NET_TID      = 8,
   parameter int BW_SLV_TID      = 2,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [BW_NET_TID-1:0] i_alloc_id,
   input  logic                  i_alloc_block,
   input  logic                  i_alloc_fire,
   output logic [BW_SLV_TID-1:0] o_alloc_slot,
   output logic                  o_alloc_ok,
   input  logic [BW_SLV_TID-1:0] i_rel_slot,
   input  logic                  i_rel_fire,
   output logic [BW_NET_TID-1:0] o_lookup_tid,
   output logic                  o_empty,
   output logic                  o_unexpected
);

   localparam int BW_CNT = cnt_width(MAX_OUTSTANDING);
   localparam logic [BW_CNT-1:0] CNT_MAX = BW_CNT'(MAX_OUTSTANDING);
   localparam logic [BW_CNT-1:0] CNT_ONE = BW_CNT'(1);

   logic [BW_NET_TID-1:0] r_tid [NUM_SLOT];
   logic [BW_CNT-1:0]     r_cnt [NUM_SLOT];

   logic                  w_hit;
   logic                  w_hit_full;
   logic [BW_SLV_TID-1:0] w_hit_slot;
   logic                  w_free;
   logic [BW_SLV_TID-1:0] w_free_slot;
   logic                  w_sel;
   logic                  w_rel_live;
   logic [NUM_SLOT-1:0]   w_inc;
   logic [NUM_SLOT-1:0]   w_dec;

   // Slot search: same-TID hit wins, else lowest free slot
   always_comb begin
      w_hit       = 1'b0;
      w_hit_full  = 1'b0;
      w_hit_slot  = '0;
      w_free      = 1'b0;
      w_free_slot = '0;
      for (int i = 0; i < NUM_SLOT; i++) begin
         if (r_cnt[i] != '0 && r_tid[i] == i_alloc_id) begin
            w_hit      = 1'b1;
            w_hit_full = (r_cnt[i] >= CNT_MAX);
            w_hit_slot = BW_SLV_TID'(i);
         end
         if (r_cnt[i] == '0 && !w_free) begin
            w_free      = 1'b1;
            w_free_slot = BW_SLV_TID'(i);
         end
      end
   end

   assign w_sel        = w_hit ? !w_hit_full : w_free;
   assign o_alloc_slot = w_hit ? w_hit_slot : w_free_slot;
   assign o_alloc_ok   = w_sel & ~i_alloc_block;

   // Response lookup; dead or out-of-range slots give TID 0
   always_comb begin
      w_rel_live   = 1'b0;
      o_lookup_tid = '0;
      for (int i = 0; i < NUM_SLOT; i++) begin
         if (i_rel_slot == BW_SLV_TID'(i) && r_cnt[i] != '0) begin
            w_rel_live   = 1'b1;
            o_lookup_tid = r_tid[i];
         end
      end
   end

   assign o_unexpected = i_rel_fire & ~w_rel_live;

   // Per-slot increment/decrement strobes and table-empty flag
   always_comb begin
      w_inc   = '0;
      w_dec   = '0;
      o_empty = 1'b1;
      for (int i = 0; i < NUM_SLOT; i++) begin
         w_inc[i] = i_alloc_fire && (o_alloc_slot == BW_SLV_TID'(i));
         w_dec[i] = i_rel_fire && w_rel_live &&
                    (i_rel_slot == BW_SLV_TID'(i));
         if (r_cnt[i] != '0) begin
            o_empty = 1'b0;
         end
      end
   end

   // Slot state update; alloc and release together cancel
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_SLOT; i++) begin
            r_tid[i] <= '0;
            r_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_SLOT; i++) begin
            if (w_inc[i]) begin
               r_tid[i] <= i_alloc_id;
            end
            if (w_inc[i] && !w_dec[i]) begin
               r_cnt[i] <= r_cnt[i] + CNT_ONE;
            end else if (w_dec[i] && !w_inc[i]) begin
               r_cnt[i] <= r_cnt[i] - CNT_ONE;
            end
         end
      end
   end

endmodule

// File: rtl/munoc_axi_slave_tid_remapper.sv
// AXI slave-side TID remapper: handshake gating around
// independent write and read slot tables.
module munoc_axi_slave_tid_remapper
   import munoc_axi_slave_tid_remapper_pkg::*;
#(
   parameter int BW_NET_TID      = 8,
   parameter int BW_SLV_TID      = 2,
   parameter int NUM_WR_SLOT     = 4,
   parameter int NUM_RD_SLOT     = 4,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  comm_disable,
   input  logic [BW_NET_TID-1:0] up_awid,
   input  logic                  up_awvalid,
   output logic                  up_awready,
   output logic [BW_SLV_TID-1:0] dn_awid,
   output logic                  dn_awvalid,
   input  logic                  dn_awready,
   input  logic [BW_SLV_TID-1:0] dn_bid,
   input  logic                  dn_bvalid,
   output logic                  dn_bready,
   output logic [BW_NET_TID-1:0] up_bid,
   output logic                  up_bvalid,
   input  logic                  up_bready,
   input  logic [BW_NET_TID-1:0] up_arid,
   input  logic                  up_arvalid,
   output logic                  up_arready,
   output logic [BW_SLV_TID-1:0] dn_arid,
   output logic                  dn_arvalid,
   input  logic                  dn_arready,
   input  logic [BW_SLV_TID-1:0] dn_rid,
   input  logic                  dn_rlast,
   input  logic                  dn_rvalid,
   output logic                  dn_rready,
   output logic [BW_NET_TID-1:0] up_rid,
   output logic                  up_rlast,
   output logic                  up_rvalid,
   input  logic                  up_rready,
   output logic                  idle,
   output logic                  err_unexpected
);

   if (!params_ok(BW_SLV_TID, NUM_WR_SLOT, NUM_RD_SLOT,
                  MAX_OUTSTANDING)) begin : g_bad_params
      $error("munoc_axi_slave_tid_remapper: illegal parameters");
   end

   logic w_wr_ok;
   logic w_rd_ok;
   logic w_aw_fire;
   logic w_ar_fire;
   logic w_b_fire;
   logic w_r_rel;
   logic w_wr_empty;
   logic w_rd_empty;
   logic w_wr_unexp;
   logic w_rd_unexp;
   logic r_err;

   assign dn_awvalid = up_awvalid & w_wr_ok;
   assign up_awready = dn_awready & w_wr_ok;
   assign w_aw_fire  = up_awvalid & dn_awready & w_wr_ok;

   assign dn_arvalid = up_arvalid & w_rd_ok;
   assign up_arready = dn_arready & w_rd_ok;
   assign w_ar_fire  = up_arvalid & dn_arready & w_rd_ok;

   assign up_bvalid = dn_bvalid;
   assign dn_bready = up_bready;
   assign w_b_fire  = dn_bvalid & up_bready;

   assign up_rvalid = dn_rvalid;
   assign up_rlast  = dn_rlast;
   assign dn_rready = up_rready;
   assign w_r_rel   = dn_rvalid & up_rready & dn_rlast;

   munoc_tid_slot_table #(
      .NUM_SLOT        (NUM_WR_SLOT),
      .BW_NET_TID      (BW_NET_TID),
      .BW_SLV_TID      (BW_SLV_TID),
      .MAX_OUTSTANDING (MAX_OUTSTANDING)
   ) u_wr_table (
      .clk           (clk),
      .rst           (rst),
      .i_alloc_id    (up_awid),
      .i_alloc_block (comm_disable),
      .i_alloc_fire  (w_aw_fire),
      .o_alloc_slot  (dn_awid),
      .o_alloc_ok    (w_wr_ok),
      .i_rel_slot    (dn_bid),
      .i_rel_fire    (w_b_fire),
      .o_lookup_tid  (up_bid),
      .o_empty       (w_wr_empty),
      .o_unexpected  (w_wr_unexp)
   );

   munoc_tid_slot_table #(
      .NUM_SLOT        (NUM_RD_SLOT),
      .BW_NET_TID      (BW_NET_TID),
      .BW_SLV_TID      (BW_SLV_TID),
      .MAX_OUTSTANDING (MAX_OUTSTANDING)
   ) u_rd_table (
      .clk           (clk),
      .rst           (rst),
      .i_alloc_id    (up_arid),
      .i_alloc_block (comm_disable),
      .i_alloc_fire  (w_ar_fire),
      .o_alloc_slot  (dn_arid),
      .o_alloc_ok    (w_rd_ok),
      .i_rel_slot    (dn_rid),
      .i_rel_fire    (w_r_rel),
      .o_lookup_tid  (up_rid),
      .o_empty       (w_rd_empty),
      .o_unexpected  (w_rd_unexp)
   );

   assign idle           = w_wr_empty & w_rd_empty;
   assign err_unexpected = r_err;

   // Sticky flag for responses that match no live slot
   always_ff @(posedge clk) begin
      if (rst) begin
         r_err <= 1'b0;
      end else if (w_wr_unexp || w_rd_unexp) begin
         r_err <= 1'b1;
      end
   end

endmodule
